// File: rtl/keypad_scanner.sv
// keypad_scanner: parametrised matrix-keypad scanner with debounce.
// Drives one row at a time, samples active-low columns at the end of each
// settle window, confirms a key after DEBOUNCE_SCANS matching samples and
// holds the resulting code under a valid/ready handshake until consumed.
// Optional build macro: KEYSCAN_GHOST_REJECT_EN -- when defined, a sample
// with more than one low column is treated as no key at all.
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_SCANS = 3,
    localparam int CW = ($clog2(ROWS * COLS) > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] key_col,
    output logic [ROWS-1:0] key_row,
    output logic [CW-1:0]   key_code,
    output logic            key_valid,
    input  logic            key_ready,
    output logic            key_down,
    output logic            key_overrun
);

    localparam int RW = ($clog2(ROWS) > 1) ? $clog2(ROWS) : 1;
    localparam int SW = ($clog2(SETTLE_CYCLES) > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int NW = ($clog2(DEBOUNCE_SCANS + 1) > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;

    typedef enum logic [1:0] {
        SCAN,
        CONFIRM,
        HELD
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [NW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cand_q, cand_d;

    logic [COLS-1:0] low;
    logic            any_low;
    logic            cand_valid;
    logic [CW-1:0]   cand_code;
    logic            sample;
    logic            confirm;
    logic [NW-1:0]   cnt_inc;
    logic [RW-1:0]   row_adv;

    assign low     = ~key_col;
    assign any_low = |low;
    assign sample  = (settle_q == SW'(SETTLE_CYCLES - 1));
    assign cnt_inc = cnt_q + NW'(1);
    assign row_adv = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);

`ifdef KEYSCAN_GHOST_REJECT_EN
    assign cand_valid = any_low && ((low & (low - COLS'(1))) == '0);
`else
    assign cand_valid = any_low;
`endif

    // Lowest-index low column on the driven row gives the candidate code.
    always_comb begin
        cand_code = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (low[c]) begin
                cand_code = CW'(int'(row_q) * COLS + c);
            end
        end
    end

    // State register: scan position, settle timer, debounce counter, candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SCAN;
            row_q    <= '0;
            settle_q <= '0;
            cnt_q    <= '0;
            cand_q   <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            settle_q <= settle_d;
            cnt_q    <= cnt_d;
            cand_q   <= cand_d;
        end
    end

    // Next-state logic: everything except the settle timer moves only on a sample.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        settle_d = settle_q + SW'(1);
        cnt_d    = cnt_q;
        cand_d   = cand_q;
        confirm  = 1'b0;
        if (sample) begin
            settle_d = '0;
            case (state_q)
                SCAN: begin
                    if (cand_valid) begin
                        cand_d = cand_code;
                        if (DEBOUNCE_SCANS == 1) begin
                            confirm = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            state_d = CONFIRM;
                            cnt_d   = NW'(1);
                        end
                    end else begin
                        row_d = row_adv;
                    end
                end
                CONFIRM: begin
                    if (cand_valid && (cand_code == cand_q)) begin
                        if (cnt_inc == NW'(DEBOUNCE_SCANS)) begin
                            confirm = 1'b1;
                            state_d = HELD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = SCAN;
                        row_d   = row_adv;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (any_low) begin
                        cnt_d = '0;
                    end else if (cnt_inc == NW'(DEBOUNCE_SCANS)) begin
                        state_d = SCAN;
                        row_d   = row_adv;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = SCAN;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from the state register: row drive and held-key level.
    always_comb begin
        key_row  = ROWS'(1) << row_q;
        key_down = (state_q == HELD);
    end

    // Key output register: load on confirm when free or being consumed, else flag overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_code    <= '0;
            key_valid   <= 1'b0;
            key_overrun <= 1'b0;
        end else begin
            key_overrun <= 1'b0;
            if (confirm) begin
                if (!key_valid || key_ready) begin
                    key_code  <= cand_code;
                    key_valid <= 1'b1;
                end else begin
                    key_overrun <= 1'b1;
                end
            end else if (key_valid && key_ready) begin
                key_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: self-checking bench for keypad_scanner at default size.
// A keypad model pulls columns low for pressed keys on the driven row;
// expected outputs come from timing formulas of the scanning rules.
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready;
    logic       key_down;
    logic       key_overrun;
    logic [15:0] pressed;

    int tests_run;
    int fails;

    keypad_scanner dut (
        .clk         (clk),
        .rst         (rst),
        .key_col     (key_col),
        .key_row     (key_row),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_down    (key_down),
        .key_overrun (key_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key grounds its column while its row is driven.
    always_comb begin
        key_col = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
            end
        end
    end

    function automatic logic [3:0] onehot(input int r);
        logic [3:0] v;
        v = 4'b0001 << r;
        return v;
    endfunction

    // Leaves the bench 1 time unit after the clock edge that starts cycle 0.
    task automatic do_reset();
        rst       = 1'b1;
        pressed   = '0;
        key_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        tests_run++;
        if (key_row !== 4'b0001) begin fails++; $display("[TB] FAIL reset_row got %b want 0001", key_row); end
        tests_run++;
        if (key_code !== 4'd0) begin fails++; $display("[TB] FAIL reset_code got %0d want 0", key_code); end
        tests_run++;
        if (key_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got %b want 0", key_valid); end
        tests_run++;
        if (key_down !== 1'b0) begin fails++; $display("[TB] FAIL reset_down got %b want 0", key_down); end
        tests_run++;
        if (key_overrun !== 1'b0) begin fails++; $display("[TB] FAIL reset_overrun got %b want 0", key_overrun); end
    endtask

    task automatic test_idle();
        do_reset();
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            tests_run++;
            if (key_row !== onehot((n / 4) % 4) || key_valid !== 1'b0 || key_down !== 1'b0) begin
                fails++;
                $display("[TB] FAIL idle n=%0d row=%b valid=%b down=%b want row=%b valid=0 down=0",
                         n, key_row, key_valid, key_down, onehot((n / 4) % 4));
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_press_release();
        for (int it = 0; it < 6; it++) begin
            int r, c, tv, a, m, f1, tdown, er;
            logic ev, ed;
            r     = $urandom_range(0, 3);
            c     = $urandom_range(0, 3);
            tv    = 4 * r + 12;
            a     = tv + $urandom_range(0, 8);
            m     = 4 * r + 14 + $urandom_range(0, 16);
            f1    = m + (3 - (m % 4));
            tdown = f1 + 9;
            do_reset();
            for (int n = 0; n <= tdown + 10; n++) begin
                pressed   = (n < m) ? (16'd1 << (4 * r + c)) : 16'd0;
                key_ready = (n == a);
                @(negedge clk);
                if (n < 4 * r) er = n / 4;
                else if (n < tdown) er = r;
                else er = (r + 1 + (n - tdown) / 4) % 4;
                ev = (n >= tv) && (n <= a);
                ed = (n >= tv) && (n < tdown);
                tests_run++;
                if (key_row !== onehot(er) || key_valid !== ev || key_down !== ed || key_overrun !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL press key=%0d n=%0d row=%b valid=%b down=%b ovr=%b want row=%b valid=%b down=%b ovr=0",
                             4 * r + c, n, key_row, key_valid, key_down, key_overrun, onehot(er), ev, ed);
                end
                if (n >= tv) begin
                    tests_run++;
                    if (key_code !== 4'(4 * r + c)) begin
                        fails++;
                        $display("[TB] FAIL press_code n=%0d got %0d want %0d", n, key_code, 4 * r + c);
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        key_ready = 1'b0;
    endtask

    task automatic test_bounce();
        for (int it = 0; it < 4; it++) begin
            int r, c, k, m, tadv, er;
            r    = $urandom_range(0, 3);
            c    = $urandom_range(0, 3);
            k    = $urandom_range(1, 2);
            m    = 4 * r + 4 * k;
            tadv = m + 4;
            do_reset();
            for (int n = 0; n <= tadv + 16; n++) begin
                pressed = (n < m) ? (16'd1 << (4 * r + c)) : 16'd0;
                @(negedge clk);
                if (n < 4 * r) er = n / 4;
                else if (n < tadv) er = r;
                else er = (r + 1 + (n - tadv) / 4) % 4;
                tests_run++;
                if (key_row !== onehot(er) || key_valid !== 1'b0 || key_down !== 1'b0) begin
                    fails++;
                    $display("[TB] FAIL bounce k=%0d n=%0d row=%b valid=%b down=%b want row=%b valid=0 down=0",
                             k, n, key_row, key_valid, key_down, onehot(er));
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 6; it++) begin
            int r1, c1, r2, c2, tv1, m1, tdown, d, w, ld, er, ec;
            logic ack, ed, eo;
            r1    = $urandom_range(0, 3);
            c1    = $urandom_range(0, 3);
            r2    = $urandom_range(0, 3);
            c2    = $urandom_range(0, 3);
            ack   = (it % 2) == 1;
            tv1   = 4 * r1 + 12;
            m1    = 4 * r1 + 16;
            tdown = 4 * r1 + 28;
            d     = (r2 - r1 - 1 + 8) % 4;
            w     = tdown + 4 * d;
            ld    = w + 11;
            do_reset();
            for (int n = 0; n <= ld + 6; n++) begin
                pressed = '0;
                if (n < m1) pressed = pressed | (16'd1 << (4 * r1 + c1));
                if (n >= tdown) pressed = pressed | (16'd1 << (4 * r2 + c2));
                key_ready = ack && (n == ld);
                @(negedge clk);
                if (n < 4 * r1) er = n / 4;
                else if (n < tdown) er = r1;
                else if (n < w) er = (r1 + 1 + (n - tdown) / 4) % 4;
                else er = r2;
                ed = ((n >= tv1) && (n < tdown)) || (n > ld);
                eo = !ack && (n == ld + 1);
                ec = (ack && n > ld) ? 4 * r2 + c2 : 4 * r1 + c1;
                tests_run++;
                if (key_row !== onehot(er) || key_valid !== (n >= tv1) || key_down !== ed || key_overrun !== eo) begin
                    fails++;
                    $display("[TB] FAIL b2b ack=%0b n=%0d row=%b valid=%b down=%b ovr=%b want row=%b valid=%b down=%b ovr=%b",
                             ack, n, key_row, key_valid, key_down, key_overrun, onehot(er), (n >= tv1), ed, eo);
                end
                if (n >= tv1) begin
                    tests_run++;
                    if (key_code !== 4'(ec)) begin
                        fails++;
                        $display("[TB] FAIL b2b_code ack=%0b n=%0d got %0d want %0d", ack, n, key_code, ec);
                    end
                end
                @(posedge clk);
                #1;
            end
        end
        key_ready = 1'b0;
    endtask

    task automatic test_multi_column();
        do_reset();
        for (int n = 0; n <= 30; n++) begin
            logic [3:0] erow;
            logic       ev;
            pressed = 16'b0000_0000_0000_0110;
`ifdef KEYSCAN_GHOST_REJECT_EN
            erow = onehot((n / 4) % 4);
            ev   = 1'b0;
`else
            erow = 4'b0001;
            ev   = (n >= 12);
`endif
            @(negedge clk);
            tests_run++;
            if (key_row !== erow || key_valid !== ev || key_down !== ev) begin
                fails++;
                $display("[TB] FAIL multi n=%0d row=%b valid=%b down=%b want row=%b valid=%b down=%b",
                         n, key_row, key_valid, key_down, erow, ev, ev);
            end
            if (ev) begin
                tests_run++;
                if (key_code !== 4'd1) begin
                    fails++;
                    $display("[TB] FAIL multi_code n=%0d got %0d want 1", n, key_code);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        int r, c, tv;
        r  = $urandom_range(0, 3);
        c  = $urandom_range(0, 3);
        tv = 4 * r + 12;
        do_reset();
        pressed = 16'd1 << (4 * r + c);
        for (int n = 0; n <= tv + 1; n++) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (key_valid !== 1'b1) begin fails++; $display("[TB] FAIL midreset_pre valid got %b want 1", key_valid); end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (key_row !== 4'b0001 || key_code !== 4'd0 || key_valid !== 1'b0 || key_down !== 1'b0 || key_overrun !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midreset row=%b code=%0d valid=%b down=%b ovr=%b want 0001 0 0 0 0",
                     key_row, key_code, key_valid, key_down, key_overrun);
        end
        rst     = 1'b0;
        pressed = '0;
    endtask

    initial begin
        tests_run = 0;
        fails     = 0;
        rst       = 1'b1;
        key_ready = 1'b0;
        pressed   = '0;
        test_reset();
        test_idle();
        test_press_release();
        test_bounce();
        test_back_to_back();
        test_multi_column();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
